// File: rtl/mips8_pkg.sv
// Shared definitions for the nd-mips8 core: default widths plus the ALU and
// next-PC encodings that the controller drives into the datapath.
package mips8_pkg;

    localparam int MIPS8_WIDTH   = 8;
    localparam int MIPS8_REGBITS = 3;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_src_e;

endpackage

// File: rtl/mips8_regfile.sv
// Two-read one-write register file with combinational reads; r0 is hard-wired
// to zero on both read ports and writes to it are dropped.
module mips8_regfile
    import mips8_pkg::*;
#(
    parameter int WIDTH   = MIPS8_WIDTH,
    parameter int REGBITS = MIPS8_REGBITS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we_i,
    input  logic [REGBITS-1:0] ra1_i,
    input  logic [REGBITS-1:0] ra2_i,
    input  logic [REGBITS-1:0] wa_i,
    input  logic [WIDTH-1:0]   wd_i,
    output logic [WIDTH-1:0]   rd1_o,
    output logic [WIDTH-1:0]   rd2_o
);

    localparam int NREGS = 1 << REGBITS;

    logic [WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Reads see the stored value, so a same-cycle write is visible next cycle.
    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mips8_datapath.sv
// Multicycle 8-bit datapath for nd-mips8: PC, byte-assembled instruction
// register, MDR/A/B/ALUOut holding registers, ALU and the register file.
module mips8_datapath
    import mips8_pkg::*;
#(
    parameter int WIDTH   = MIPS8_WIDTH,
    parameter int REGBITS = MIPS8_REGBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] memdata,
    input  logic             alusrca,
    input  logic             memtoreg,
    input  logic             iord,
    input  logic             pcen,
    input  logic             regwrite,
    input  logic             regdst,
    input  logic [1:0]       pcsrc,
    input  logic             alusrcb,
    input  logic [2:0]       alucontrol,
    input  logic [3:0]       irwrite,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             zero,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata
);

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [WIDTH-1:0]   mdr_q, a_q, b_q, aluout_q;
    logic [WIDTH-1:0]   rd1, rd2, regWd;
    logic [WIDTH-1:0]   srca, srcb, aluResult, pcNext;
    logic [WIDTH-1:0]   wordOffset, immediate;
    logic [REGBITS-1:0] writeIdx;

    assign wordOffset = WIDTH'({instr_q[5:0], 2'b00});
    assign immediate  = WIDTH'(instr_q[7:0]);

    always_comb begin
        instr_d = instr_q;
        for (int b = 0; b < 4; b++) begin
            if (irwrite[b]) begin
                instr_d[8*b +: 8] = memdata[7:0];
            end
        end
    end

    assign writeIdx = regdst ? instr_q[11 +: REGBITS] : instr_q[16 +: REGBITS];
    assign regWd    = memtoreg ? mdr_q : aluout_q;

    mips8_regfile #(
        .WIDTH   (WIDTH),
        .REGBITS (REGBITS)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (regwrite),
        .ra1_i   (instr_q[21 +: REGBITS]),
        .ra2_i   (instr_q[16 +: REGBITS]),
        .wa_i    (writeIdx),
        .wd_i    (regWd),
        .rd1_o   (rd1),
        .rd2_o   (rd2)
    );

    assign srca = alusrca ? a_q : pc_q;

    // The second operand depends on both selects: PC-relative vs register forms.
    always_comb begin
        srcb = '0;
        case ({alusrca, alusrcb})
            2'b00:   srcb = WIDTH'(1);
            2'b01:   srcb = wordOffset;
            2'b10:   srcb = b_q;
            2'b11:   srcb = immediate;
            default: srcb = '0;
        endcase
    end

    always_comb begin
        aluResult = '0;
        case (alucontrol)
            ALU_AND: aluResult = srca & srcb;
            ALU_OR:  aluResult = srca | srcb;
            ALU_ADD: aluResult = srca + srcb;
            ALU_SUB: aluResult = srca - srcb;
            ALU_SLT: aluResult = WIDTH'(srca < srcb);
            default: aluResult = '0;
        endcase
    end

    always_comb begin
        pcNext = pc_q;
        case (pcsrc)
            PC_ALU:    pcNext = aluResult;
            PC_ALUOUT: pcNext = aluout_q;
            PC_JUMP:   pcNext = wordOffset;
            PC_HOLD:   pcNext = pc_q;
            default:   pcNext = pc_q;
        endcase
    end

    assign pc_d = pcen ? pcNext : pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= '0;
            instr_q  <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            mdr_q    <= memdata;
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= aluResult;
        end
    end

    assign op        = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign zero      = (aluResult == '0);
    assign adr       = iord ? aluout_q : pc_q;
    assign writedata = b_q;

endmodule

// File: doc/mips8_datapath.md
# mips8_datapath

Multicycle 8-bit datapath for the nd-mips8 core: the consumer of every control strobe the `controller` FSM issues and the producer of the `op`, `funct` and `zero` status it decodes. It owns the following state, all updated under the controller's enables:
- PC
- byte-assembled 32-bit instruction register
- memory-data register
- A/B/ALUOut holding registers
- eight-entry register file

It also generates the memory address and write data toward the external memory.

## Interface
- `WIDTH`, 8: datapath and address width.
- `REGBITS`, 3: register-file index width (8 registers).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous assert, active-low; all state cleared.
- `memdata` in WIDTH: read data from memory.
- `alusrca` in 1: 0 selects PC, 1 selects A.
- `memtoreg` in 1: register write data; 0 selects ALUOut, 1 selects MDR.
- `iord` in 1: address select; 0 selects PC, 1 selects ALUOut.
- `pcen` in 1: PC load enable.
- `regwrite` in 1: register-file write enable.
- `regdst` in 1: write index; 0 selects `instr[18:16]`, 1 selects `instr[13:11]`.
- `pcsrc` in 2: next-PC select.
- `alusrcb` in 1: second ALU operand select (see Operation).
- `alucontrol` in 3: ALU function.
- `irwrite` in 4: per-byte instruction-register load enables.
- `op` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `zero` out 1: combinational, 1 when the ALU result is 0.
- `adr` out WIDTH: memory address.
- `writedata` out WIDTH: register B, for stores.

## Operation
- **Instruction register.** `irwrite[3]` loads `instr[31:24]` from `memdata`; `irwrite[2]` loads `[23:16]`, `irwrite[1]` loads `[15:8]`, `irwrite[0]` loads `[7:0]`. Multiple bits may be set together; each loads its own byte. Bytes whose bit is clear hold their value.
- **Unconditional registers.** MDR, A, B and ALUOut load every cycle from `memdata`, `rd1`, `rd2` and the ALU result respectively.
- **Register file.** Read indices are `instr[23:21]` (to A) and `instr[18:16]` (to B). Reads are combinational. r0 always reads 0; writes to r0 are discarded.
- **Register write.** Data is `memtoreg ? MDR : ALUOut`, written at the edge while `regwrite`=1.
- **Operand selection.** srca = `alusrca ? A : PC`. srcb is selected as follows:
  - `alusrca`=0, `alusrcb`=0: constant 1 (byte-wise PC increment).
  - `alusrca`=0, `alusrcb`=1: `{instr[5:0],2'b00}` (branch offset).
  - `alusrca`=1, `alusrcb`=0: B.
  - `alusrca`=1, `alusrcb`=1: `instr[7:0]` (immediate).
- **ALU functions.** `alucontrol` encodes:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT: result 1 if `srca < srcb`, unsigned compare, else 0.
  - Other codes produce 0.
- **Arithmetic width.** Results are modulo 2^WIDTH; carry and overflow are discarded.
- **Next PC.** Loaded only when `pcen`=1, selected by `pcsrc`:
  - 00: ALU result.
  - 01: ALUOut.
  - 10: `{instr[5:0],2'b00}` (jump).
  - 11: current PC (no change).
- **Address.** `adr` = `iord ? ALUOut : PC`.

## Timing
- **Reset (`reset_n`=0).** Asynchronously clears PC, instr, MDR, A, B, ALUOut and all registers to 0.
- **Outputs at reset.** `op`=0, `funct`=0, `writedata`=0, and `adr`=0 when `iord`=0. `zero` follows the combinational ALU on the held-zero state.
- **Release of reset.** State loads on the first rising edge with `reset_n`=1. Reset asserted mid-fetch discards any partially assembled instruction.
- **Latency.**
  - `op`/`funct` update the cycle after the corresponding `irwrite` edge.
  - A and B reflect the new instruction one edge after the last byte loads.
  - ALUOut lags the ALU by one edge.
- **Register-file hazards.** Write-then-read of the same index in the same cycle returns the old value to A/B; the new value is visible the following cycle.
- **Combinational outputs.** `zero` and `adr` have no register stage.

## Structure
- **Shared package `mips8_pkg`.** Holds:
  - `WIDTH` and `REGBITS` defaults.
  - ALU encodings: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`.
  - PC-source encodings: `PC_ALU`, `PC_ALUOUT`, `PC_JUMP`, `PC_HOLD`.
  
  The controller uses the same package.
- **Sub-module `mips8_regfile`.** 2R1W, asynchronous-reset, r0 hard-zero. All other logic is flat.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-run with `iord`=0 → `adr`=0, `op`=0, `funct`=0, and all registers read 0 after release.
- **Fetch.** Drive `memdata` = 8'h20, 8'h43, 8'h00, 8'h05 with `irwrite` = 1000, 0100, 0010, 0001 on four edges, each with `pcen`=1, `pcsrc`=00, `alusrca`=0, `alusrcb`=0 → `op`=6'h08, `funct`=6'h05, PC=4.
- **ALU functions.** Preload r2=7 and r3=9, set `alusrca`=1, `alusrcb`=0, sweep `alucontrol` (B=r3=9) →
  - ADD = 16
  - SUB = 254
  - AND = 1
  - OR = 15
  - SLT = 1
  
  `zero`=1 only when SUB is applied with equal operands.
- **r0 protection.** Write 8'hFF with `regdst` selecting r0 → r0 still reads 0; the same write to r5 reads back 8'hFF the next cycle.
- **Branch and jump.** With `instr[5:0]`=6'h03 and PC=8 → branch target via `alusrcb`=1 is 20; `pcsrc`=10 loads PC=12; `pcsrc`=11 with `pcen`=1 leaves PC unchanged.
- **Memory path.** Set `iord`=1 with ALUOut=8'h40 → `adr`=8'h40. Set `memtoreg`=1 with MDR=8'h5A and `regwrite`=1 → the destination reads 8'h5A.
